multi_pwm: RTL and testbench
============================

Name: multi_pwm

Overview:
- Multi-channel, parametrised successor to the single-channel PWM generator.
- One shared period counter drives CHANNELS comparators, with:
  - programmable period and clock prescaler;
  - edge-aligned or center-aligned mode;
  - double-buffered (shadow) duty/period/mode registers that take effect only at a period boundary, so outputs never glitch.
- Sits between the control register file and the motor/LED drivers.

Parameters:
- BIT, 6, width of the counter, period and each duty value.
- CHANNELS, 4, number of independent PWM outputs.
- PRE_BITS, 8, width of the prescaler divide value.

Ports:
- clk_in  input  1  system clock, all logic on rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- enable_in  input  1  run when high; halt and force outputs low when low.
- prescale_in  input  PRE_BITS  tick generated every prescale_in+1 clocks.
- period_in  input  BIT  period value P (pending copy).
- center_in  input  1  0 = edge-aligned, 1 = center-aligned (pending copy).
- duty_in  input  CHANNELS*BIT  packed duties; channel i is bits [i*BIT +: BIT].
- load_in  input  1  one-clock strobe; captures period_in, center_in and duty_in into the shadow registers.
- PWM_out  output  CHANNELS  registered PWM outputs.
- cycle_start_out  output  1  one-clock pulse marking the first count of each period.
- pending_out  output  1  high while shadow values await transfer.

Behaviour:
- Reset (async, rst_n_in low): all of the following clear to 0 immediately:
  - prescaler, counter and direction (direction = up);
  - active and shadow registers;
  - pending_out, PWM_out, cycle_start_out.
- Reset asserted mid-period aborts the period; after release the block behaves as if fresh from reset.
- Prescaler: counts 0..prescale_in and asserts an internal tick on the clock where it equals prescale_in, then returns to 0. prescale_in=0 gives a tick every clock. prescale_in is not shadowed and takes effect immediately.
- Shadow load:
  - load_in high captures the inputs into the shadow registers and sets pending_out on the next clock.
  - A repeat load before transfer overwrites the shadow; the last load wins.
- Transfer: shadow moves to active and pending_out clears on a boundary tick (below). If load_in and a boundary tick coincide, the transfer uses the old shadow contents and pending_out stays 1 with the new values.
- Edge mode (active P):
  - Counter goes 0,1,..,P, then 0 on the next tick; period = P+1 ticks.
  - Boundary tick = tick where the counter wraps P→0.
- Center mode (active P):
  - Counter counts up 0..P-1, holds P-1 one tick while the direction flips to down, counts down to 0, holds 0 one tick while the direction flips to up.
  - Period = 2P ticks.
  - Boundary tick = tick where the direction flips down→up.
- P=0 (either mode): counter held at 0; every tick is a boundary tick.
- Compare:
  - On every clock, PWM_out[i] <= enable_in & (counter < duty_active[i]).
  - Latency: one clock after the counter value.
- Duty results:
  - duty=0 gives a constant low.
  - Edge mode: high for min(duty, P+1) ticks per period; duty > P gives a constant high.
  - Center mode: high for 2·min(duty, P) ticks, centred on the counter-zero region; duty ≥ P gives a constant high.
  - P=0: constant high iff duty≠0.
- cycle_start_out:
  - High for exactly one clock, aligned with the PWM_out sample of counter=0 at the start of each period (including the first period after enable).
  - When prescale_in>0, the pulse is still one clk_in cycle wide.
- Disable (enable_in low):
  - Prescaler, counter and direction are held at 0/up; PWM_out = 0; cycle_start_out = 0.
  - A pending shadow transfers to active on the next clock.
- Re-enable: counting starts at 0 and the first tick is a boundary tick.
- Widths: all comparisons are unsigned at BIT bits. The counter never exceeds P, so there is no overflow for P = 2^BIT−1.

Test Plan:
- Reset, then enable with prescale_in=0, P=9, edge, duties {0,3,10,15} → ch0 always low; ch1 high 3 of every 10 clocks; ch2 and ch3 always high; cycle_start_out every 10 clocks.
- Center mode, P=4, duty ch0=2, prescale_in=0 → period 8 clocks; ch0 high 4 consecutive clocks spanning the counter-zero hold; cycle_start_out every 8 clocks.
- Mid-period load_in changes ch1 duty 3→7 (P=9, edge) → old duty persists until the wrap; the new duty takes effect exactly at the next cycle_start_out; pending_out 1→0 on that boundary.
- prescale_in=2, P=3, duty=2, edge → period 12 clocks; high 6 clocks; cycle_start_out one clock wide.
- load_in coincident with a boundary tick → old shadow applied; pending_out stays high; new values applied at the following boundary.
- Assert rst_n_in for 1 clock mid-period, and separately drop enable_in → all outputs 0 immediately (reset) or next clock (disable); restart from counter 0 with cycle_start_out on the first count.

Source files
------------

// File: rtl/multi_pwm_if.sv
// Control/status bundle between the register file (master) and the multi-channel PWM (slave).
interface multi_pwm_if #(
  parameter int BIT      = 6,
  parameter int CHANNELS = 4,
  parameter int PRE_BITS = 8
);
  logic                     enable_in;
  logic [PRE_BITS-1:0]      prescale_in;
  logic [BIT-1:0]           period_in;
  logic                     center_in;
  logic [CHANNELS*BIT-1:0]  duty_in;
  logic                     load_in;
  logic [CHANNELS-1:0]      PWM_out;
  logic                     cycle_start_out;
  logic                     pending_out;

  modport master (
    output enable_in, prescale_in, period_in, center_in, duty_in, load_in,
    input  PWM_out, cycle_start_out, pending_out
  );

  modport slave (
    input  enable_in, prescale_in, period_in, center_in, duty_in, load_in,
    output PWM_out, cycle_start_out, pending_out
  );
endinterface

// File: rtl/multi_pwm.sv
// Multi-channel PWM: one shared prescaled period counter (edge or center aligned) feeding
// CHANNELS comparators, with shadowed period/mode/duty that switch only at period boundaries.
module multi_pwm #(
  parameter int BIT      = 6,
  parameter int CHANNELS = 4,
  parameter int PRE_BITS = 8
) (
  input logic       clk_in,
  input logic       rst_n_in,
  multi_pwm_if.slave bus
);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [BIT-1:0]      CNT_ZERO = {BIT{1'b0}};
  localparam logic [BIT-1:0]      CNT_ONE  = {{(BIT-1){1'b0}}, 1'b1};
  localparam logic [PRE_BITS-1:0] PRE_ZERO = {PRE_BITS{1'b0}};
  localparam logic [PRE_BITS-1:0] PRE_ONE  = {{(PRE_BITS-1){1'b0}}, 1'b1};

  logic [PRE_BITS-1:0]     presc_r;
  logic [PRE_BITS-1:0]     presc_nxt_s;
  logic [BIT-1:0]          cnt_r;
  logic [BIT-1:0]          cnt_nxt_s;
  dir_e                    dir_r;
  dir_e                    dir_nxt_s;
  logic                    first_r;
  logic                    first_nxt_s;
  logic                    bnd_d_r;

  logic [BIT-1:0]          per_sh_r;
  logic                    ctr_sh_r;
  logic [CHANNELS*BIT-1:0] duty_sh_r;
  logic [BIT-1:0]          per_act_r;
  logic                    ctr_act_r;
  logic [CHANNELS*BIT-1:0] duty_act_r;
  logic                    pending_r;
  logic                    pending_nxt_s;

  logic [CHANNELS-1:0]     pwm_r;
  logic [CHANNELS-1:0]     pwm_nxt_s;
  logic                    cs_r;

  logic                    tick_s;
  logic                    wrap_s;
  logic                    boundary_s;
  logic                    xfer_s;
  logic [BIT-1:0]          per_m1_s;

  // Tick, wrap and boundary detection; a period ends at the wrap (edge) or down->up flip (center).
  always_comb begin
    tick_s   = bus.enable_in & (presc_r >= bus.prescale_in);
    per_m1_s = per_act_r - CNT_ONE;
    if (per_act_r == CNT_ZERO) begin
      wrap_s = 1'b1;
    end else if (ctr_act_r) begin
      wrap_s = (dir_r == DIR_DOWN) && (cnt_r == CNT_ZERO);
    end else begin
      wrap_s = (cnt_r >= per_act_r);
    end
    boundary_s = tick_s & (first_r | wrap_s);
    xfer_s     = pending_r & (boundary_s | ~bus.enable_in);
  end

  // Next-state for prescaler, counter and count direction.
  always_comb begin
    presc_nxt_s = presc_r;
    cnt_nxt_s   = cnt_r;
    dir_nxt_s   = dir_r;
    first_nxt_s = first_r;
    if (!bus.enable_in) begin
      presc_nxt_s = PRE_ZERO;
      cnt_nxt_s   = CNT_ZERO;
      dir_nxt_s   = DIR_UP;
      first_nxt_s = 1'b1;
    end else if (!tick_s) begin
      presc_nxt_s = presc_r + PRE_ONE;
    end else begin
      presc_nxt_s = PRE_ZERO;
      first_nxt_s = 1'b0;
      if (boundary_s) begin
        cnt_nxt_s = CNT_ZERO;
        dir_nxt_s = DIR_UP;
      end else if (!ctr_act_r) begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end else begin
        case (dir_r)
          DIR_UP: begin
            if (cnt_r >= per_m1_s) begin
              dir_nxt_s = DIR_DOWN;
            end else begin
              cnt_nxt_s = cnt_r + CNT_ONE;
            end
          end
          DIR_DOWN: cnt_nxt_s = cnt_r - CNT_ONE;
          default: begin
            cnt_nxt_s = CNT_ZERO;
            dir_nxt_s = DIR_UP;
          end
        endcase
      end
    end
  end

  // Pending flag: a load always re-arms it, even when it coincides with a transfer.
  always_comb begin
    if (bus.load_in) begin
      pending_nxt_s = 1'b1;
    end else if (xfer_s) begin
      pending_nxt_s = 1'b0;
    end else begin
      pending_nxt_s = pending_r;
    end
  end

  // Per-channel compare against the live counter.
  always_comb begin
    pwm_nxt_s = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_nxt_s[i] = bus.enable_in & (cnt_r < duty_act_r[i*BIT +: BIT]);
    end
  end

  // Counter state registers; first_r resets high so the first enabled tick opens a period.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      presc_r <= PRE_ZERO;
      cnt_r   <= CNT_ZERO;
      dir_r   <= DIR_UP;
      first_r <= 1'b1;
      bnd_d_r <= 1'b0;
    end else begin
      presc_r <= presc_nxt_s;
      cnt_r   <= cnt_nxt_s;
      dir_r   <= dir_nxt_s;
      first_r <= first_nxt_s;
      bnd_d_r <= boundary_s;
    end
  end

  // Shadow and active configuration; transfer reads the shadow before a same-cycle load lands.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      per_sh_r   <= CNT_ZERO;
      ctr_sh_r   <= 1'b0;
      duty_sh_r  <= {(CHANNELS*BIT){1'b0}};
      per_act_r  <= CNT_ZERO;
      ctr_act_r  <= 1'b0;
      duty_act_r <= {(CHANNELS*BIT){1'b0}};
      pending_r  <= 1'b0;
    end else begin
      if (bus.load_in) begin
        per_sh_r  <= bus.period_in;
        ctr_sh_r  <= bus.center_in;
        duty_sh_r <= bus.duty_in;
      end else begin
        per_sh_r  <= per_sh_r;
        ctr_sh_r  <= ctr_sh_r;
        duty_sh_r <= duty_sh_r;
      end
      if (xfer_s) begin
        per_act_r  <= per_sh_r;
        ctr_act_r  <= ctr_sh_r;
        duty_act_r <= duty_sh_r;
      end else begin
        per_act_r  <= per_act_r;
        ctr_act_r  <= ctr_act_r;
        duty_act_r <= duty_act_r;
      end
      pending_r <= pending_nxt_s;
    end
  end

  // Registered outputs; the delayed boundary lines the start pulse up with the count-0 sample.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pwm_r <= {CHANNELS{1'b0}};
      cs_r  <= 1'b0;
    end else begin
      pwm_r <= pwm_nxt_s;
      cs_r  <= bus.enable_in & bnd_d_r;
    end
  end

  assign bus.PWM_out         = pwm_r;
  assign bus.cycle_start_out = cs_r;
  assign bus.pending_out     = pending_r;

endmodule

// File: tb/tb_multi_pwm.sv
// Directed self-checking bench for multi_pwm: edge/center modes, shadow loads, prescaler,
// reset and disable behaviour, with expected waveforms derived from the counter sequence.
module tb_multi_pwm;

  logic clk;
  logic rst_n;
  int   total_cnt = 0;
  int   pass_cnt  = 0;
  int   fail_cnt  = 0;

  multi_pwm_if #(.BIT(6), .CHANNELS(4), .PRE_BITS(8)) bus ();

  multi_pwm #(.BIT(6), .CHANNELS(4), .PRE_BITS(8)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] dv(input int d3, input int d2, input int d1, input int d0);
    logic [5:0] a3, a2, a1, a0;
    a3 = 6'(d3); a2 = 6'(d2); a1 = 6'(d1); a0 = 6'(d0);
    return {a3, a2, a1, a0};
  endfunction

  // Load a configuration while disabled, let it transfer, then enable.
  task automatic start_cfg(input int pre, input int per, input logic ctr, input logic [23:0] duty);
    bus.enable_in   = 1'b0;
    bus.prescale_in = 8'(pre);
    bus.period_in   = 6'(per);
    bus.center_in   = ctr;
    bus.duty_in     = duty;
    bus.load_in     = 1'b1;
    step(1);
    bus.load_in     = 1'b0;
    step(1);
    bus.enable_in   = 1'b1;
  endtask

  initial begin
    logic       ch1;
    logic [3:0] pexp;
    int         t;
    rst_n           = 1'b0;
    bus.enable_in   = 1'b0;
    bus.prescale_in = 8'd0;
    bus.period_in   = 6'd0;
    bus.center_in   = 1'b0;
    bus.duty_in     = 24'd0;
    bus.load_in     = 1'b0;
    step(2);
    chk("rst_pwm", {28'd0, bus.PWM_out}, 32'd0);
    chk("rst_cs", {31'd0, bus.cycle_start_out}, 32'd0);
    chk("rst_pend", {31'd0, bus.pending_out}, 32'd0);
    rst_n = 1'b1;

    // Edge mode P=9, duties {15,10,3,0}
    bus.period_in = 6'd9;
    bus.center_in = 1'b0;
    bus.duty_in   = dv(15, 10, 3, 0);
    bus.load_in   = 1'b1;
    step(1);
    bus.load_in   = 1'b0;
    chk("load_pend", {31'd0, bus.pending_out}, 32'd1);
    step(1);
    chk("dis_xfer_pend", {31'd0, bus.pending_out}, 32'd0);
    bus.enable_in = 1'b1;
    step(1);
    for (int n = 1; n <= 20; n++) begin
      step(1);
      ch1  = ((n - 1) % 10) < 3;
      pexp = {2'b11, ch1, 1'b0};
      chk($sformatf("e9_pwm_%0d", n), {28'd0, bus.PWM_out}, {28'd0, pexp});
      chk($sformatf("e9_cs_%0d", n), {31'd0, bus.cycle_start_out}, {31'd0, ((n - 1) % 10) == 0});
    end

    // Mid-period load: ch1 3->7 at edge 25, active from the boundary at edge 30
    bus.duty_in = dv(15, 10, 7, 0);
    for (int n = 21; n <= 41; n++) begin
      bus.load_in = (n == 25);
      step(1);
      bus.load_in = 1'b0;
      ch1  = (n >= 31) ? (((n - 1) % 10) < 7) : (((n - 1) % 10) < 3);
      pexp = {2'b11, ch1, 1'b0};
      chk($sformatf("ml_pwm_%0d", n), {28'd0, bus.PWM_out}, {28'd0, pexp});
      chk($sformatf("ml_cs_%0d", n), {31'd0, bus.cycle_start_out}, {31'd0, ((n - 1) % 10) == 0});
      chk($sformatf("ml_pend_%0d", n), {31'd0, bus.pending_out}, {31'd0, (n >= 25 && n < 30)});
    end

    // Load ch1=2 at edge 45, then ch1=5 exactly on the boundary at edge 50
    for (int n = 42; n <= 71; n++) begin
      if (n == 45) begin
        bus.duty_in = dv(15, 10, 2, 0);
        bus.load_in = 1'b1;
      end else if (n == 50) begin
        bus.duty_in = dv(15, 10, 5, 0);
        bus.load_in = 1'b1;
      end else begin
        bus.load_in = 1'b0;
      end
      step(1);
      bus.load_in = 1'b0;
      t    = (n <= 50) ? 7 : ((n <= 60) ? 2 : 5);
      ch1  = ((n - 1) % 10) < t;
      pexp = {2'b11, ch1, 1'b0};
      chk($sformatf("cb_pwm_%0d", n), {28'd0, bus.PWM_out}, {28'd0, pexp});
      chk($sformatf("cb_pend_%0d", n), {31'd0, bus.pending_out}, {31'd0, (n >= 45 && n < 60)});
      chk($sformatf("cb_cs_%0d", n), {31'd0, bus.cycle_start_out}, {31'd0, ((n - 1) % 10) == 0});
    end

    // Asynchronous reset mid-period with a pending load outstanding
    bus.load_in = 1'b1;
    step(1);
    bus.load_in = 1'b0;
    chk("pre_rst_pend", {31'd0, bus.pending_out}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pwm", {28'd0, bus.PWM_out}, 32'd0);
    chk("arst_cs", {31'd0, bus.cycle_start_out}, 32'd0);
    chk("arst_pend", {31'd0, bus.pending_out}, 32'd0);
    step(1);
    rst_n = 1'b1;

    // Restart after reset, then disable mid-period and reload ch1=4 while disabled
    start_cfg(0, 9, 1'b0, dv(15, 10, 3, 0));
    step(1);
    step(1);
    chk("rs_cs1", {31'd0, bus.cycle_start_out}, 32'd1);
    chk("rs_pwm1", {28'd0, bus.PWM_out}, 32'he);
    step(1);
    chk("rs_cs2", {31'd0, bus.cycle_start_out}, 32'd0);
    chk("rs_pwm2", {28'd0, bus.PWM_out}, 32'he);
    bus.enable_in = 1'b0;
    chk("dis_pwm_hold", {28'd0, bus.PWM_out}, 32'he);
    step(1);
    chk("dis_pwm", {28'd0, bus.PWM_out}, 32'd0);
    chk("dis_cs", {31'd0, bus.cycle_start_out}, 32'd0);
    bus.duty_in = dv(15, 10, 4, 0);
    bus.load_in = 1'b1;
    step(1);
    bus.load_in = 1'b0;
    chk("dis_load_pend", {31'd0, bus.pending_out}, 32'd1);
    step(1);
    chk("dis_xfer2_pend", {31'd0, bus.pending_out}, 32'd0);
    chk("dis_pwm2", {28'd0, bus.PWM_out}, 32'd0);
    bus.enable_in = 1'b1;
    step(1);
    for (int m = 1; m <= 11; m++) begin
      step(1);
      ch1  = ((m - 1) % 10) < 4;
      pexp = {2'b11, ch1, 1'b0};
      chk($sformatf("re_pwm_%0d", m), {28'd0, bus.PWM_out}, {28'd0, pexp});
      chk($sformatf("re_cs_%0d", m), {31'd0, bus.cycle_start_out}, {31'd0, (m == 1 || m == 11)});
    end

    // Center mode P=4, ch0 duty 2: counter 0,1,2,3,3,2,1,0 per period
    start_cfg(0, 4, 1'b1, dv(0, 0, 0, 2));
    step(1);
    for (int n = 1; n <= 17; n++) begin
      step(1);
      t = (n - 1) % 8;
      chk($sformatf("ctr_pwm_%0d", n), {28'd0, bus.PWM_out}, {31'd0, (t < 2 || t > 5)});
      chk($sformatf("ctr_cs_%0d", n), {31'd0, bus.cycle_start_out}, {31'd0, t == 0});
    end

    // Prescale 2, P=3, duty 2: first tick on the third enabled clock, period 12 clocks
    start_cfg(2, 3, 1'b0, dv(0, 0, 0, 2));
    for (int n = 1; n <= 28; n++) begin
      step(1);
      if (n < 4) begin
        chk($sformatf("pre_pwm_%0d", n), {28'd0, bus.PWM_out}, 32'd1);
        chk($sformatf("pre_cs_%0d", n), {31'd0, bus.cycle_start_out}, 32'd0);
      end else begin
        t = (n - 4) % 12;
        chk($sformatf("pre_pwm_%0d", n), {28'd0, bus.PWM_out}, {31'd0, t < 6});
        chk($sformatf("pre_cs_%0d", n), {31'd0, bus.cycle_start_out}, {31'd0, t == 0});
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
